// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame parameters.
package uart_pkg;

  localparam int DEF_D_BITS    = 8;
  localparam int DEF_S_TICKS   = 16;
  localparam int DEF_STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } state_t;

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Received-word handshake bundle between the UART receiver (master) and its consumer (slave).
// rx_valid high means rx_data/frame_err/parity_err hold an unconsumed word and stay stable;
// the word transfers on any rising clk edge where rx_valid & rx_ready are both high.
interface uart_rx_cfg_if #(
  parameter int D_BITS = 8
) ();

  logic [D_BITS-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    output rx_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with held output word, valid/ready handshake and overrun pulse.
// Optional parity checking is built when the macro UART_RX_PARITY_EN is defined.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int D_BITS     = DEF_D_BITS,
  parameter int S_TICKS    = DEF_S_TICKS,
  parameter int STOP_BITS  = DEF_STOP_BITS,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 tick,
  uart_rx_cfg_if.master        rx_if,
  output logic                 overrun,
  output logic                 busy,
  output state_t               dbg_state
);

  localparam int SW = $clog2(S_TICKS);
  localparam int NW = $clog2(D_BITS);
  localparam logic [SW-1:0] S_MID  = SW'(S_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(S_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(D_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic              stop_q, stop_d;
  logic [D_BITS-1:0] shift_q, shift_d;
  logic              ferr_acc_q, ferr_acc_d;
  logic              perr_acc_q, perr_acc_d;
  logic [D_BITS-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              overrun_q, overrun_d;
  logic              commit;
  logic              frame_now;

`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_BIT = 1'(PARITY_ODD);
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // Frame error for the word being committed includes the stop sample taken this cycle.
  assign frame_now = ferr_acc_q | ~rx_s;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    stop_d       = stop_q;
    shift_d      = shift_q;
    ferr_acc_d   = ferr_acc_q;
    perr_acc_d   = perr_acc_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    commit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d    = DATA;
              s_d        = '0;
              n_d        = '0;
              ferr_acc_d = 1'b0;
              perr_acc_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            shift_d = {rx_s, shift_q[D_BITS-1:1]};
            s_d     = '0;
            if (n_q == N_LAST) begin
              state_d = AFTER_DATA;
              stop_d  = 1'b0;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            perr_acc_d = (((^shift_q) ^ rx_s) != PARITY_BIT);
            s_d        = '0;
            stop_d     = 1'b0;
            state_d    = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            if (stop_q == STOP_LAST) begin
              commit  = 1'b1;
              state_d = frame_now ? BRK : IDLE;
            end else begin
              stop_d     = stop_q + 1'b1;
              ferr_acc_d = frame_now;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      BRK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && rx_if.rx_ready) valid_d = 1'b0;

    // A commit lands if the slot is empty or being drained this cycle; otherwise it is dropped.
    if (commit) begin
      if (!valid_q || rx_if.rx_ready) begin
        data_d       = shift_q;
        frame_err_d  = frame_now;
        parity_err_d = perr_acc_q;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      ferr_acc_q   <= 1'b0;
      perr_acc_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      ferr_acc_q   <= ferr_acc_d;
      perr_acc_q   <= perr_acc_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.parity_err = parity_err_q;
  assign overrun          = overrun_q;
  assign busy             = (state_q != IDLE);
  assign dbg_state        = state_q;

endmodule
